// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory responder: FSM states,
// fault codes, default depth and the store-beat data selector.
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC0 = 2'd1,
        ST_ACC1 = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam logic [1:0] FAULT_NONE  = 2'b00;
    localparam logic [1:0] FAULT_STACK = 2'b01;
    localparam logic [1:0] FAULT_ADDR  = 2'b10;

    localparam int DEFAULT_MEM_DEPTH = 4096;

    // Stack accesses put the upper half at the first word, so their 32-bit
    // beats are swapped relative to ordinary accesses.
    function automatic logic [15:0] beat_data(
        input logic [31:0] wdata,
        input logic        en32,
        input logic        stack,
        input logic        second
    );
        logic [15:0] half;
        if (!second)
            half = (en32 && stack) ? wdata[31:16] : wdata[15:0];
        else
            half = stack ? wdata[15:0] : wdata[31:16];
        return half;
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// Single-port 16-bit data RAM: synchronous write, synchronous (registered) read.
module dmem_bank #(
    parameter int DEPTH = 4096,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [15:0]       wdata,
    output logic [15:0]       rdata
);

    logic [15:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
        rdata <= mem[addr];
    end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle load/store/stack responder over a 16-bit word RAM.
// Define DATA_MEM_FAULT_EN to enable address/stack fault detection.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int MEM_DEPTH = DEFAULT_MEM_DEPTH,
    localparam int ADDR_W = $clog2(MEM_DEPTH)
) (
    input  logic        clk,
    input  logic        i_reset_n,
    input  logic        i_req,
    input  logic        i_write,
    input  logic        i_en32,
    input  logic        i_isStack,
    input  logic [31:0] i_address,
    input  logic [31:0] i_wdata,
    output logic        o_ready,
    output logic        o_done,
    output logic [31:0] o_rdata,
    output logic [1:0]  o_fault
);

    state_t state, next_state;

    logic              accept;
    logic [1:0]        fault_now;
    logic [ADDR_W-1:0] acc_w0, acc_w1;

    logic              req_write, req_en32, req_stack;
    logic [ADDR_W-1:0] w0_addr, w1_addr;
    logic [31:0]       req_wdata;
    logic [15:0]       beat0_hold;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [15:0]       ram_wdata, ram_rdata;

    assign accept = (state == ST_IDLE) && i_req;
    assign acc_w0 = i_address[ADDR_W-1:0];
    assign acc_w1 = i_isStack ? acc_w0 - ADDR_W'(1) : acc_w0 + ADDR_W'(1);

`ifdef DATA_MEM_FAULT_EN
    // Bounds are judged on the full 32-bit address before any truncation.
    always_comb begin
        fault_now = FAULT_NONE;
        if (i_isStack) begin
            if (i_address >= 32'(MEM_DEPTH) || (i_en32 && i_address == 32'd0))
                fault_now = FAULT_STACK;
        end else begin
            if (i_address >= 32'(MEM_DEPTH) ||
                (i_en32 && (i_address + 32'd1) >= 32'(MEM_DEPTH)))
                fault_now = FAULT_ADDR;
        end
    end
`else
    logic unused_addr_hi;
    assign fault_now      = FAULT_NONE;
    assign unused_addr_hi = ^i_address[31:ADDR_W];
`endif

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        o_ready    = 1'b0;
        o_done     = 1'b0;
        case (state)
            ST_IDLE: begin
                o_ready = 1'b1;
                if (i_req)
                    next_state = (fault_now != FAULT_NONE) ? ST_RESP : ST_ACC0;
            end
            ST_ACC0: next_state = req_en32 ? ST_ACC1 : ST_RESP;
            ST_ACC1: next_state = ST_RESP;
            ST_RESP: begin
                o_done     = 1'b1;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            req_write <= i_write;
            req_en32  <= i_en32;
            req_stack <= i_isStack;
            req_wdata <= i_wdata;
            w0_addr   <= acc_w0;
            w1_addr   <= acc_w1;
        end
    end

    // Reads are addressed one cycle ahead (W0 at accept, W1 during ACC0) so
    // each beat's data is on the RAM output while its ACC state is active.
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = w0_addr;
        ram_wdata = 16'h0000;
        case (state)
            ST_IDLE: ram_addr = acc_w0;
            ST_ACC0: begin
                if (req_write) begin
                    ram_we    = 1'b1;
                    ram_addr  = w0_addr;
                    ram_wdata = beat_data(req_wdata, req_en32, req_stack, 1'b0);
                end else begin
                    ram_addr = w1_addr;
                end
            end
            ST_ACC1: begin
                ram_addr = w1_addr;
                if (req_write) begin
                    ram_we    = 1'b1;
                    ram_wdata = beat_data(req_wdata, req_en32, req_stack, 1'b1);
                end
            end
            default: ram_addr = w0_addr;
        endcase
    end

    dmem_bank #(
        .DEPTH (MEM_DEPTH)
    ) u_bank (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (state == ST_ACC0 && !req_write)
            beat0_hold <= ram_rdata;
    end

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_rdata <= 32'h0;
            o_fault <= FAULT_NONE;
        end else begin
            if (next_state == ST_RESP)
                o_fault <= (state == ST_IDLE) ? fault_now : FAULT_NONE;
            if (!req_write) begin
                if (state == ST_ACC0 && !req_en32)
                    o_rdata <= {16'h0000, ram_rdata};
                else if (state == ST_ACC1)
                    o_rdata <= req_stack ? {beat0_hold, ram_rdata}
                                         : {ram_rdata, beat0_hold};
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder against a word-level memory model.
module tb_data_mem_responder;

    localparam int DEPTH = 4096;

    logic        clk = 1'b0;
    logic        i_reset_n;
    logic        i_req;
    logic        i_write;
    logic        i_en32;
    logic        i_isStack;
    logic [31:0] i_address;
    logic [31:0] i_wdata;
    logic        o_ready;
    logic        o_done;
    logic [31:0] o_rdata;
    logic [1:0]  o_fault;

    int checks   = 0;
    int failures = 0;

    logic [15:0] mem_m [DEPTH];
    logic [31:0] rdata_m;

    always #5 clk = ~clk;

    data_mem_responder dut (
        .clk       (clk),
        .i_reset_n (i_reset_n),
        .i_req     (i_req),
        .i_write   (i_write),
        .i_en32    (i_en32),
        .i_isStack (i_isStack),
        .i_address (i_address),
        .i_wdata   (i_wdata),
        .o_ready   (o_ready),
        .o_done    (o_done),
        .o_rdata   (o_rdata),
        .o_fault   (o_fault)
    );

    // Reference: which words a request touches, what it returns, how long it takes.
    task automatic model_req(input bit wr, input bit en32, input bit stk,
                             input logic [31:0] a, input logic [31:0] wd,
                             output logic [31:0] e_rd, output logic [1:0] e_f,
                             output int e_lat);
        int base, lo_idx, hi_idx;
        e_f = 2'b00;
`ifdef DATA_MEM_FAULT_EN
        if (stk) begin
            if (a >= 32'd4096 || (en32 && a == 32'd0)) e_f = 2'b01;
        end else if (a >= 32'd4096 || (en32 && (a + 32'd1) >= 32'd4096)) begin
            e_f = 2'b10;
        end
`endif
        if (e_f != 2'b00) begin
            e_lat = 0;
            e_rd  = rdata_m;
            return;
        end
        base = int'(a & 32'h0000_0FFF);
        if (!en32) begin
            if (wr) mem_m[base] = wd[15:0];
            else    rdata_m = {16'h0000, mem_m[base]};
            e_lat = 1;
        end else begin
            lo_idx = stk ? (base + DEPTH - 1) % DEPTH : base;
            hi_idx = stk ? base : (base + 1) % DEPTH;
            if (wr) begin
                mem_m[lo_idx] = wd[15:0];
                mem_m[hi_idx] = wd[31:16];
            end else begin
                rdata_m = {mem_m[hi_idx], mem_m[lo_idx]};
            end
            e_lat = 2;
        end
        e_rd = rdata_m;
    endtask

    // Entered just after a negedge with the DUT idle; returns at the negedge after RESP.
    task automatic do_req(input bit wr, input bit en32, input bit stk,
                          input logic [31:0] a, input logic [31:0] wd, input string nm);
        logic [31:0] e_rd;
        logic [1:0]  e_f;
        int          e_lat;
        int          k;
        bit          busy_bad;
        model_req(wr, en32, stk, a, wd, e_rd, e_f, e_lat);
        checks++;
        if (o_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s ready_before: got %b want 1", nm, o_ready);
        end
        i_req = 1'b1; i_write = wr; i_en32 = en32; i_isStack = stk;
        i_address = a; i_wdata = wd;
        @(posedge clk);
        #1;
        i_req = 1'b0; i_write = 1'($urandom); i_en32 = 1'($urandom);
        i_isStack = 1'($urandom); i_address = $urandom; i_wdata = $urandom;
        k = 0;
        busy_bad = 1'b0;
        @(negedge clk);
        while (o_done !== 1'b1 && k < 8) begin
            if (o_ready !== 1'b0) busy_bad = 1'b1;
            @(negedge clk);
            k++;
        end
        if (o_ready !== 1'b0) busy_bad = 1'b1;
        checks++;
        if (k !== e_lat) begin
            failures++;
            $display("FAIL %s latency: got %0d want %0d", nm, k, e_lat);
        end
        checks++;
        if (busy_bad !== 1'b0) begin
            failures++;
            $display("FAIL %s ready_busy: got ready=1 while busy want 0", nm);
        end
        checks++;
        if (o_rdata !== e_rd) begin
            failures++;
            $display("FAIL %s rdata: got %h want %h", nm, o_rdata, e_rd);
        end
        checks++;
        if (o_fault !== e_f) begin
            failures++;
            $display("FAIL %s fault: got %b want %b", nm, o_fault, e_f);
        end
        @(negedge clk);
        checks++;
        if (o_done !== 1'b0 || o_ready !== 1'b1 || o_fault !== e_f) begin
            failures++;
            $display("FAIL %s after_done: got done=%b ready=%b fault=%b want 0 1 %b",
                     nm, o_done, o_ready, o_fault, e_f);
        end
    endtask

    task automatic check_reset_outputs(input string nm);
        checks++;
        if (o_ready !== 1'b1 || o_done !== 1'b0 || o_rdata !== 32'h0 || o_fault !== 2'b00) begin
            failures++;
            $display("FAIL %s: got ready=%b done=%b rdata=%h fault=%b want 1 0 00000000 00",
                     nm, o_ready, o_done, o_rdata, o_fault);
        end
    endtask

    task automatic test_reset();
        i_reset_n = 1'b0; i_req = 1'b0; i_write = 1'b0; i_en32 = 1'b0;
        i_isStack = 1'b0; i_address = 32'h0; i_wdata = 32'h0;
        rdata_m = 32'h0;
        #1;
        check_reset_outputs("reset_initial");
        #20;
        @(negedge clk);
        i_reset_n = 1'b1;
    endtask

    task automatic test_basic16();
        do_req(1, 0, 0, 32'h0010, 32'h0000_1234, "st16_0010");
        do_req(0, 0, 0, 32'h0010, 32'hFFFF_FFFF, "ld16_0010");
    endtask

    task automatic test_async_reset();
        #1;
        i_reset_n = 1'b0;
        #1;
        rdata_m = 32'h0;
        check_reset_outputs("reset_async");
        @(negedge clk);
        i_reset_n = 1'b1;
    endtask

    task automatic test_store32();
        do_req(1, 1, 0, 32'h0020, 32'hDEAD_BEEF, "st32_0020");
        do_req(0, 0, 0, 32'h0020, 32'h0, "ld16_0020");
        do_req(0, 0, 0, 32'h0021, 32'h0, "ld16_0021");
        do_req(0, 1, 0, 32'h0020, 32'h0, "ld32_0020");
    endtask

    task automatic test_stack32();
        do_req(1, 1, 1, 32'h0FFF, 32'h8000_0005, "stk_st32_0fff");
        do_req(0, 0, 0, 32'h0FFF, 32'h0, "ld16_0fff");
        do_req(0, 0, 0, 32'h0FFE, 32'h0, "ld16_0ffe");
        do_req(0, 1, 1, 32'h0FFF, 32'h0, "stk_ld32_0fff");
    endtask

    task automatic test_boundary();
        do_req(1, 0, 0, 32'h0000, 32'h0000_0A0A, "pre_st_0000");
        do_req(1, 0, 0, 32'h0FFF, 32'h0000_0B0B, "pre_st_0fff");
        do_req(0, 0, 0, 32'h1000, 32'h0, "ld16_1000");
        do_req(1, 1, 0, 32'h0FFF, 32'h1111_2222, "st32_0fff");
        do_req(1, 1, 1, 32'h0000, 32'h3333_4444, "stk_st32_0000");
        do_req(0, 0, 0, 32'h0000, 32'h0, "chk_ld_0000");
        do_req(0, 0, 0, 32'h0FFF, 32'h0, "chk_ld_0fff");
        do_req(0, 1, 1, 32'hFFFF_FFFF, 32'h0, "stk_ld32_big");
    endtask

    task automatic test_abort();
        do_req(1, 0, 0, 32'h0030, 32'h0000_FFFF, "pre_st_0030");
        do_req(1, 0, 0, 32'h0031, 32'h0000_FFFF, "pre_st_0031");
        do_req(0, 0, 0, 32'h0031, 32'h0, "pre_ld_0031");
        i_req = 1'b1; i_write = 1'b1; i_en32 = 1'b1; i_isStack = 1'b0;
        i_address = 32'h0030; i_wdata = 32'hAAAA_5555;
        @(posedge clk);
        #1;
        i_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        i_reset_n = 1'b0;
        #1;
        mem_m[32'h30] = 16'h5555;
        rdata_m = 32'h0;
        check_reset_outputs("reset_abort");
        @(negedge clk);
        i_reset_n = 1'b1;
        do_req(0, 0, 0, 32'h0030, 32'h0, "abort_ld_0030");
        do_req(0, 0, 0, 32'h0031, 32'h0, "abort_ld_0031");
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int i = 0; i < 64; i++)
            do_req(1, 0, 0, 32'h0100 + 32'(i), $urandom, "rnd_init");
        for (int i = 0; i < 60; i++) begin
            a = 32'h0101 + 32'($urandom_range(0, 61));
            do_req(1'($urandom), 1'($urandom), 1'($urandom), a, $urandom, "rnd_op");
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            do_req(1, 1, 0, 32'h0200 + 32'(2 * i), {16'hC000 + 16'(i), 16'h0C00 + 16'(i)}, "b2b_st");
            do_req(0, 1, 0, 32'h0200 + 32'(2 * i), 32'h0, "b2b_ld");
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic16();
        test_async_reset();
        test_store32();
        test_stack32();
        test_boundary();
        test_abort();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
